// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control stage: ALUOp classes, R-type funct
// and I-type opcode values, and the 4-bit ALU control codes.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_ctrl_if.sv
// Decode-request / ALU-control handshake bundle between ID and EX.
// master: the control stage; slave: the surrounding pipeline.
interface alu_ctrl_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [5:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_ctrl;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        input  in_valid, in_aluop, in_funct, in_opcode, in_tag, out_ready,
        output in_ready, out_valid, alu_ctrl, out_tag, out_illegal
    );

    modport slave (
        output in_valid, in_aluop, in_funct, in_opcode, in_tag, out_ready,
        input  in_ready, out_valid, alu_ctrl, out_tag, out_illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct/opcode -> ALU control decode; unsupported
// encodings fall back to ADD and raise illegal.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output alu_ctrl_e  ctrl,
    output logic       illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        ctrl    = CTRL_ADD;
        illegal = 1'b0;
        unique case (aluop)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = CTRL_ADD;
                    FUNCT_SUB: ctrl = CTRL_SUB;
                    FUNCT_AND: ctrl = CTRL_AND;
                    FUNCT_OR:  ctrl = CTRL_OR;
                    FUNCT_SLT: ctrl = CTRL_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode)
                    OP_ADDI: ctrl = CTRL_ADD;
                    OP_ANDI: ctrl = CTRL_AND;
                    OP_ORI:  ctrl = CTRL_OR;
                    OP_SLTI: ctrl = CTRL_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            default: ctrl = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decode followed by a registered 2-entry skid buffer.
// Optional macro ALU_CTRL_ILLEGAL_CNT_EN adds a saturating illegal_count output.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int TAG_W     = 8,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    alu_ctrl_if.master           bus
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    output logic [ILL_CNT_W-1:0] illegal_count
`endif
);

    typedef struct packed {
        logic [3:0]       ctrl;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam entry_t ENTRY_RST = '{ctrl: CTRL_ADD, illegal: 1'b0, tag: '0};

    alu_ctrl_e dec_ctrl;
    logic      dec_illegal;
    entry_t    new_entry;
    entry_t    head_q, head_d, skid_q, skid_d;
    occ_e      occ_q, occ_d;
    logic      ready_q;
    logic      accept, pop;

    alu_ctrl_decode u_decode (
        .aluop   (bus.in_aluop),
        .funct   (bus.in_funct),
        .opcode  (bus.in_opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign accept    = bus.in_valid & ready_q;
    assign pop       = (occ_q != OCC_EMPTY) & bus.out_ready;
    assign new_entry = '{ctrl: dec_ctrl, illegal: dec_illegal, tag: bus.in_tag};

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    head_d = new_entry;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    head_d = new_entry;
                end else if (accept) begin
                    skid_d = new_entry;
                    occ_d  = OCC_TWO;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d = skid_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        // Flush only clears occupancy; stale data behind it is never shown.
        if (flush) occ_d = OCC_EMPTY;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state.
        if (reset) begin
            occ_q   <= OCC_EMPTY;
            ready_q <= 1'b1;
            // NOTE: data registers are reset too so outputs are never X after reset.
            head_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
        end else begin
            occ_q   <= occ_d;
            ready_q <= (occ_d != OCC_TWO);
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = (occ_q != OCC_EMPTY);
    assign bus.alu_ctrl    = head_q.ctrl;
    assign bus.out_tag     = head_q.tag;
    assign bus.out_illegal = head_q.illegal;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_count <= '0;
        end else if (accept && dec_illegal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Producer side of the primary ALU's 4-bit control interface.
- Decodes ALUOp, funct and opcode into the ALU control code, then delivers it through a registered 2-entry skid buffer with valid/ready handshake.
- Sits between ID and EX of the pipelined MIPS core. Carries an opaque tag (destination/PC index) alongside each decode.

Parameters:
TAG_W, 8, width of the opaque payload carried with each decode
ILL_CNT_W, 16, width of the illegal-decode counter (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  discard all buffered entries (branch/exception)
in_valid  input  1  upstream offers a decode request
in_ready  output  1  stage can accept (registered)
in_aluop  input  2  00 add, 01 sub, 10 R-type by funct, 11 I-type by opcode
in_funct  input  6  instr[5:0]
in_opcode  input  6  instr[31:26]
in_tag  input  TAG_W  payload
out_valid  output  1  decoded entry available
out_ready  input  1  EX consumes entry
alu_ctrl  output  4  ALU control code
out_tag  output  TAG_W  payload of head entry
out_illegal  output  1  head entry had an unsupported encoding

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). All state changes on the rising edge of clk.
- Reset values: out_valid=0, in_ready=1, alu_ctrl=4'b0010, out_tag=0, out_illegal=0, occupancy=0.
- Decode (combinational, before buffering):
  - aluop 00 -> 0010. aluop 01 -> 0110.
  - aluop 10, funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111.
  - aluop 11, opcode: 001000->0010, 001100->0000, 001101->0001, 001010->0111.
  - Any other funct/opcode -> 0010 with illegal=1.
- Buffer: 2 entries (head, skid) of {ctrl[3:0], illegal, tag}.
  - Accept when in_valid & in_ready. Pop when out_valid & out_ready.
  - Latency: an entry accepted at edge N is visible on outputs after edge N (out_valid=1 in cycle N+1).
  - in_ready = (occupancy<2), registered from next-state occupancy, so it never depends combinationally on out_ready.
  - Simultaneous accept and pop with occupancy 1: skid stays empty; head takes the new entry.
  - Occupancy 2: in_ready=0; a pop moves skid to head.
  - Empty with pop asserted: no effect.
  - Order is strictly FIFO. Outputs are held stable while out_valid & !out_ready.
  - Non-head outputs are don't-care when out_valid=0, but must not contain X after reset.
- Flush: occupancy->0, out_valid=0, in_ready=1 on the next edge. Flush has priority over a same-cycle accept (the accepted entry is dropped) and over a pop.
- Reset has priority over flush. Reset mid-transfer discards all entries.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_CNT_EN.
  - Defined: adds output illegal_count [ILL_CNT_W-1:0]. It increments on each accepted entry with illegal=1, saturates at all-ones, is cleared by reset, and is not cleared by flush.
  - Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Package alu_pkg: ALUOp constants, funct constants, opcode constants, 4-bit ALU control codes (AND/OR/ADD/SUB/SLT).
- Sub-module alu_ctrl_decode: purely combinational {aluop, funct, opcode} -> {ctrl, illegal}.
- alu_ctrl_stage instantiates alu_ctrl_decode and owns the skid buffer, handshake and counter.

Test Plan:
- Reset, then aluop=10 funct=101010 tag=0x5A, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0111, out_tag=0x5A, out_illegal=0.
- out_ready=0; send aluop=00 then aluop=01 -> in_ready=0 after 2nd accept. A 3rd offer is not accepted. Raise out_ready -> 0010 then 0110 in order, in_ready=1 again.
- aluop=11 opcode=001101 -> 0001. aluop=10 funct=000000 -> alu_ctrl=0010, out_illegal=1. With ALU_CTRL_ILLEGAL_CNT_EN, illegal_count=1.
- Occupancy 2 and flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry dropped.
- Continuous in_valid with out_ready=1, 8 funct codes back-to-back -> 1 result per cycle in order, in_ready constantly 1.
- Illegal counter with ILL_CNT_W=2, 5 illegal entries -> illegal_count holds 3. Flush leaves it at 3; reset clears it to 0.
